aes_shiftrow_pipe: RTL and testbench

Registered, parametrised ShiftRows/InvShiftRows stage for the AES/Rijndael datapath. It handles any Rijndael block width (Nb = 4, 6 or 8 columns) and selects forward or inverse direction per beat. Valid/ready handshakes sit on both sides, with a small output buffer. It sits between SubBytes/InvSubBytes and MixColumns/AddRoundKey in the iterative round core.

---
 rtl/aes_shiftrow_pipe.sv | 99 +++++++++
 tb/tb_aes_shiftrow_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_shiftrow_pipe.sv
// rtl/aes_shiftrow_pipe.sv - registered ShiftRows/InvShiftRows stage with valid/ready and output FIFO
module aes_shiftrow_pipe #(
    parameter int NB    = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_inv,
    input  logic [32*NB-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*NB-1:0]    out_data,
    output logic [CNT_W-1:0]    blk_cnt
);

    localparam int W  = 32 * NB;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("aes_shiftrow_pipe: NB must be 4, 6 or 8");
        end
        if (DEPTH < 1) begin : g_bad_depth
            $error("aes_shiftrow_pipe: DEPTH must be at least 1");
        end
    endgenerate

    // Rijndael 256-bit blocks skip offset 2 in rows 2 and 3.
    function automatic int row_shift(input int r);
        return (NB == 8 && r >= 2) ? r + 1 : r;
    endfunction

    logic [W-1:0] fwd;
    logic [W-1:0] inv;
    logic [W-1:0] shifted;

    always_comb begin
        fwd = '0;
        inv = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                fwd[W-1-8*(4*c+r) -: 8] =
                    in_data[W-1-8*(4*((c + row_shift(r)) % NB)+r) -: 8];
                inv[W-1-8*(4*c+r) -: 8] =
                    in_data[W-1-8*(4*((c - row_shift(r) + NB) % NB)+r) -: 8];
            end
        end
        shifted = in_inv ? inv : fwd;
    end

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Ready depends only on registered state so out_ready never reaches in_ready.
    assign in_ready  = rst_n && (count < FULL);
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            blk_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                blk_cnt <= blk_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_shiftrow_pipe.sv
// tb/tb_aes_shiftrow_pipe.sv - randomized bench with queue-based reference model for aes_shiftrow_pipe
module tb_aes_shiftrow_pipe;

    logic         clk = 1'b0;
    logic         rst4 = 1'b0;
    logic         rst8 = 1'b0;

    logic         v4, r4, inv4, ov4, ordy4;
    logic [127:0] d4, od4;
    logic [3:0]   bc4;

    logic         v8, r8, inv8, ov8, ordy8;
    logic [255:0] d8, od8;
    logic [15:0]  bc8;

    int n_checks = 0;
    int n_fail   = 0;
    bit en       = 1'b0;

    logic [127:0] q4 [$];
    logic [255:0] q8 [$];
    logic [3:0]   m4cnt;
    logic [15:0]  m8cnt;

    logic [127:0] p1, p2, p3, pq;
    logic [255:0] rnd;
    int           acc8;
    int           cyc;
    bit           push4, push8;

    always #5 clk = ~clk;

    aes_shiftrow_pipe #(.NB(4), .DEPTH(2), .CNT_W(4)) u4 (
        .clk(clk), .rst_n(rst4), .in_valid(v4), .in_ready(r4), .in_inv(inv4),
        .in_data(d4), .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .blk_cnt(bc4)
    );

    aes_shiftrow_pipe #(.NB(8), .DEPTH(2), .CNT_W(16)) u8 (
        .clk(clk), .rst_n(rst8), .in_valid(v8), .in_ready(r8), .in_inv(inv8),
        .in_data(d8), .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .blk_cnt(bc8)
    );

    // State as a 4 x nb byte matrix; each row rotated by its Rijndael offset.
    function automatic logic [255:0] shift_ref(input int nb, input logic [255:0] d, input bit inv);
        logic [7:0]   st [4][8];
        logic [7:0]   o  [4][8];
        int           s  [4];
        logic [255:0] res;
        s[0] = 0; s[1] = 1;
        s[2] = (nb == 8) ? 3 : 2;
        s[3] = (nb == 8) ? 4 : 3;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = d[32*nb-1-8*(4*c+r) -: 8];
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                o[r][c] = inv ? st[r][(c - s[r] + nb) % nb] : st[r][(c + s[r]) % nb];
        res = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                res[32*nb-1-8*(4*c+r) -: 8] = o[r][c];
        return res;
    endfunction

    function automatic logic [127:0] f4(input logic [127:0] x, input bit inv);
        logic [255:0] t;
        t = shift_ref(4, {128'h0, x}, inv);
        return t[127:0];
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (!rst4) begin
            q4.delete();
            m4cnt = '0;
        end else begin
            push4 = v4 && (q4.size() < 2);
            if (q4.size() != 0 && ordy4) void'(q4.pop_front());
            if (push4) begin
                q4.push_back(f4(d4, inv4));
                m4cnt = m4cnt + 4'd1;
            end
        end
        if (!rst8) begin
            q8.delete();
            m8cnt = '0;
        end else begin
            push8 = v8 && (q8.size() < 2);
            if (q8.size() != 0 && ordy8) void'(q8.pop_front());
            if (push8) begin
                q8.push_back(shift_ref(8, d8, inv8));
                m8cnt = m8cnt + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("in_ready4",  {255'h0, r4},  {255'h0, (rst4 && q4.size() < 2)});
            chk("out_valid4", {255'h0, ov4}, {255'h0, (q4.size() != 0)});
            chk("out_data4",  {128'h0, od4}, {128'h0, (q4.size() != 0) ? q4[0] : 128'h0});
            chk("blk_cnt4",   {252'h0, bc4}, {252'h0, m4cnt});
            chk("in_ready8",  {255'h0, r8},  {255'h0, (rst8 && q8.size() < 2)});
            chk("out_valid8", {255'h0, ov8}, {255'h0, (q8.size() != 0)});
            chk("out_data8",  od8,           (q8.size() != 0) ? q8[0] : 256'h0);
            chk("blk_cnt8",   {240'h0, bc8}, {240'h0, m8cnt});
        end
    end

    initial begin
        v4 = 0; inv4 = 0; d4 = '0; ordy4 = 0;
        v8 = 0; inv8 = 0; d8 = '0; ordy8 = 0;
        p1 = {$urandom, $urandom, $urandom, $urandom};
        p2 = {$urandom, $urandom, $urandom, $urandom};
        p3 = {$urandom, $urandom, $urandom, $urandom};
        pq = {$urandom, $urandom, $urandom, $urandom};
        tick;
        en = 1'b1;
        chk("reset_in_ready", {255'h0, r4}, 256'h0);
        chk("reset_out_valid", {255'h0, ov4}, 256'h0);
        chk("reset_out_data", {128'h0, od4}, 256'h0);
        chk("reset_blk_cnt", {252'h0, bc4}, 256'h0);

        chk("model_fwd4", {128'h0, f4(128'h000102030405060708090a0b0c0d0e0f, 1'b0)},
            {128'h0, 128'h00050a0f04090e03080d02070c01060b});
        chk("model_inv4", {128'h0, f4(128'hbc3804205138ff26eeeb9a39b31218a1, 1'b1)},
            {128'h0, 128'hbc129a2651381839ee3804a1b3ebff20});
        rnd = shift_ref(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b0);
        chk("model_nb8_r2c0", {248'h0, rnd[255-16 -: 8]}, 256'h0e);
        for (int i = 0; i < 4; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            chk("model_nb8_roundtrip", shift_ref(8, shift_ref(8, rnd, 1'b0), 1'b1), rnd);
        end

        tick;
        rst4 = 1'b1; rst8 = 1'b1;
        #1;
        chk("release_in_ready", {255'h0, r4}, 256'h1);

        tick;
        d4 = 128'h000102030405060708090a0b0c0d0e0f; inv4 = 0; v4 = 1; ordy4 = 1;
        tick;
        v4 = 0;
        chk("fwd_out_data", {128'h0, od4}, {128'h0, 128'h00050a0f04090e03080d02070c01060b});
        chk("fwd_out_valid", {255'h0, ov4}, 256'h1);
        chk("fwd_blk_cnt", {252'h0, bc4}, 256'h1);
        tick;
        chk("fwd_valid_drop", {255'h0, ov4}, 256'h0);

        d4 = 128'hbc3804205138ff26eeeb9a39b31218a1; inv4 = 1; v4 = 1;
        tick;
        d4 = 128'hbc129a2651381839ee3804a1b3ebff20; inv4 = 0;
        chk("inv_out_data", {128'h0, od4}, {128'h0, 128'hbc129a2651381839ee3804a1b3ebff20});
        tick;
        v4 = 0;
        chk("roundtrip_out_data", {128'h0, od4}, {128'h0, 128'hbc3804205138ff26eeeb9a39b31218a1});
        tick;

        ordy4 = 0; v4 = 1; d4 = p1;
        tick;
        d4 = p2;
        tick;
        chk("stall_in_ready_low", {255'h0, r4}, 256'h0);
        d4 = p3;
        tick;
        chk("stall_hold_head", {128'h0, od4}, {128'h0, f4(p1, 1'b0)});
        tick;
        chk("stall_still_head", {128'h0, od4}, {128'h0, f4(p1, 1'b0)});
        ordy4 = 1;
        tick;
        chk("drain_second", {128'h0, od4}, {128'h0, f4(p2, 1'b0)});
        chk("drain_in_ready_back", {255'h0, r4}, 256'h1);
        tick;
        v4 = 0;
        chk("drain_third", {128'h0, od4}, {128'h0, f4(p3, 1'b0)});
        tick;
        chk("drain_empty", {255'h0, ov4}, 256'h0);

        ordy4 = 0; v4 = 1; d4 = p1;
        tick;
        d4 = p2;
        tick;
        rst4 = 0;
        tick;
        chk("midrst_out_valid", {255'h0, ov4}, 256'h0);
        chk("midrst_out_data", {128'h0, od4}, 256'h0);
        chk("midrst_blk_cnt", {252'h0, bc4}, 256'h0);
        chk("midrst_in_ready", {255'h0, r4}, 256'h0);
        rst4 = 1; d4 = pq; ordy4 = 1;
        tick;
        v4 = 0;
        chk("post_rst_first", {128'h0, od4}, {128'h0, f4(pq, 1'b0)});
        tick;

        rst4 = 0;
        tick;
        rst4 = 1; v4 = 1; ordy4 = 1;
        for (int i = 1; i <= 17; i++) begin
            d4 = {$urandom, $urandom, $urandom, $urandom};
            inv4 = $urandom_range(0, 1);
            tick;
            if (i == 15) chk("cnt_15", {252'h0, bc4}, 256'd15);
            if (i == 16) chk("cnt_wrap", {252'h0, bc4}, 256'd0);
            if (i == 17) chk("cnt_after_wrap", {252'h0, bc4}, 256'd1);
        end
        v4 = 0;
        tick;

        acc8 = 0;
        cyc = 0;
        while (acc8 < 1000 && cyc < 20000) begin
            v8 = ($urandom_range(0, 3) != 0);
            inv8 = $urandom_range(0, 1);
            d8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ordy8 = ($urandom_range(0, 3) != 0);
            v4 = $urandom_range(0, 1);
            inv4 = $urandom_range(0, 1);
            d4 = {$urandom, $urandom, $urandom, $urandom};
            ordy4 = $urandom_range(0, 1);
            if (v8 && r8) acc8++;
            tick;
            cyc++;
        end
        chk("nb8_accepted_beats", 256'(acc8), 256'd1000);
        v8 = 0; v4 = 0; ordy8 = 1; ordy4 = 1;
        tick; tick; tick;
        chk("nb8_drained", {255'h0, ov8}, 256'h0);
        en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
